// File: rtl/hack_fetch_unit.sv
// hack_fetch_unit: instruction-fetch stage of the Hack CPU.
// Owns the program counter. Keeps at most one instruction-ROM read in flight.
// Hands fetched words to decode/execute over a valid/ready handshake.
// A taken jump (ex_valid & jumpctrl) redirects fetch and squashes stale words.
// Optional build macro HACK_FETCH_STATS_EN adds saturating handshake/redirect
// counters on two extra output ports.
module hack_fetch_unit #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jumpctrl,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef HACK_FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetches,
  output logic [31:0]       stat_redirects
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_nxt;
  logic              drop;
  logic              drop_nxt;
  logic [DATA_W-1:0] instr_nxt;
  logic [ADDR_W-1:0] instr_pc_nxt;
  logic              instr_valid_nxt;
  logic              redirect;
  logic              handshake;

  // A jump only counts when execute actually holds a C-instruction.
  assign redirect  = ex_valid & jumpctrl;
  assign handshake = instr_valid & instr_ready;

  // The request strobe is suppressed on a redirect because fetch_pc is about to change.
  assign rom_req  = (state == S_FETCH) & ~redirect & ~reset;
  assign rom_addr = fetch_pc;

  // Next-state and datapath-update logic for the FETCH/WAIT/FULL machine.
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    drop_nxt        = drop;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;
    unique case (state)
      S_FETCH: begin
        if (redirect) begin
          fetch_pc_nxt = jump_addr;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_nxt = jump_addr;
          if (rom_valid) begin
            // The response is consumed here, so no later word needs dropping.
            drop_nxt  = 1'b0;
            state_nxt = S_FETCH;
          end else begin
            // The read is still in flight; its response is stale when it lands.
            drop_nxt = 1'b1;
          end
        end else if (rom_valid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = S_FETCH;
          end else begin
            instr_nxt       = rom_data;
            instr_pc_nxt    = fetch_pc;
            instr_valid_nxt = 1'b1;
            fetch_pc_nxt    = fetch_pc + ADDR_W'(1);
            state_nxt       = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect) begin
          // A redirect squashes the held word even if it is accepted this cycle.
          instr_valid_nxt = 1'b0;
          fetch_pc_nxt    = jump_addr;
          state_nxt       = S_FETCH;
        end else if (handshake) begin
          instr_valid_nxt = 1'b0;
          state_nxt       = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // State and output registers, with synchronous reset to fetch from address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      fetch_pc    <= '0;
      drop        <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      drop        <= drop_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
    end
  end

`ifdef HACK_FETCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Event counters that stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetches   <= 32'd0;
      stat_redirects <= 32'd0;
    end else begin
      if (handshake) stat_fetches <= sat_inc(stat_fetches);
      if (redirect) stat_redirects <= sat_inc(stat_redirects);
    end
  end
`endif

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Directed testbench for hack_fetch_unit.
// Includes a variable-latency ROM model. A second, 4-bit-address instance
// exercises PC wrap-around.
module tb_hack_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        jumpctrl;
  logic        ex_valid;
  logic [14:0] jump_addr;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic        rom_valid;
  logic [15:0] instr;
  logic [14:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  logic        jc4;
  logic        ev4;
  logic [3:0]  ja4;
  logic        rom_req4;
  logic [3:0]  rom_addr4;
  logic [15:0] rom_data4;
  logic        rom_valid4;
  logic [15:0] instr4;
  logic [3:0]  instr_pc4;
  logic        instr_valid4;

`ifdef HACK_FETCH_STATS_EN
  logic [31:0] stat_fetches;
  logic [31:0] stat_redirects;
  logic [31:0] stat_fetches4;
  logic [31:0] stat_redirects4;
`endif

  int checks = 0;
  int failures = 0;
  int lat = 1;
  logic        pend;
  int          cnt;
  logic [14:0] paddr;

  always #5 clk = ~clk;

  hack_fetch_unit #(.ADDR_W(15), .DATA_W(16)) u_dut (
    .clk(clk), .reset(reset), .jumpctrl(jumpctrl), .ex_valid(ex_valid),
    .jump_addr(jump_addr), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_valid(rom_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef HACK_FETCH_STATS_EN
    , .stat_fetches(stat_fetches), .stat_redirects(stat_redirects)
`endif
  );

  hack_fetch_unit #(.ADDR_W(4), .DATA_W(16)) u_dut4 (
    .clk(clk), .reset(reset), .jumpctrl(jc4), .ex_valid(ev4),
    .jump_addr(ja4), .rom_req(rom_req4), .rom_addr(rom_addr4),
    .rom_data(rom_data4), .rom_valid(rom_valid4), .instr(instr4),
    .instr_pc(instr_pc4), .instr_valid(instr_valid4), .instr_ready(1'b1)
`ifdef HACK_FETCH_STATS_EN
    , .stat_fetches(stat_fetches4), .stat_redirects(stat_redirects4)
`endif
  );

  // ROM contents: an arbitrary but fixed scramble of the address.
  function automatic logic [15:0] word(input int a);
    return 16'((a * 37) ^ 32'h0000BEEF);
  endfunction

  // Main ROM: responds exactly lat cycles after the request cycle; reset abandons reads.
  always @(posedge clk) begin
    if (reset) begin
      rom_valid <= 1'b0;
      rom_data  <= 16'h0000;
      pend      <= 1'b0;
      cnt       <= 0;
      paddr     <= '0;
    end else begin
      rom_valid <= 1'b0;
      if (rom_req) begin
        if (lat == 1) begin
          rom_valid <= 1'b1;
          rom_data  <= word(int'(rom_addr));
        end else begin
          pend  <= 1'b1;
          paddr <= rom_addr;
          cnt   <= lat - 1;
        end
      end else if (pend) begin
        if (cnt == 1) begin
          rom_valid <= 1'b1;
          rom_data  <= word(int'(paddr));
          pend      <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Small ROM for the 4-bit instance: fixed one-cycle latency.
  always @(posedge clk) begin
    if (reset) begin
      rom_valid4 <= 1'b0;
      rom_data4  <= 16'h0000;
    end else begin
      rom_valid4 <= rom_req4;
      rom_data4  <= word(int'(rom_addr4));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  task automatic set_jump(input logic ev, input logic jc, input logic [14:0] ja);
    ex_valid  = ev;
    jumpctrl  = jc;
    jump_addr = ja;
  endtask

  initial begin
    reset = 1'b1;
    set_jump(1'b0, 1'b0, 15'h0000);
    instr_ready = 1'b1;
    ev4 = 1'b0;
    jc4 = 1'b0;
    ja4 = 4'h0;
    lat = 1;
    repeat (3) tick();

    // Reset state.
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);

    // Stream with k=1, ready=1: one instruction every 3 cycles. The 4-bit
    // instance jumps to 15 in cycle 0 and must wrap to 0.
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        ev4 = 1'b1; jc4 = 1'b1; ja4 = 4'hF;
      end else begin
        ev4 = 1'b0; jc4 = 1'b0;
      end
      #1;
      chk("s1_req", 32'(rom_req), 32'(c % 3 == 0));
      if (c % 3 == 0) chk("s1_addr", 32'(rom_addr), 32'(c / 3));
      chk("s1_valid", 32'(instr_valid), 32'(c % 3 == 2));
      if (c % 3 == 2) begin
        chk("s1_pc", 32'(instr_pc), 32'(c / 3));
        chk("s1_instr", 32'(instr), 32'(word(c / 3)));
      end
`ifdef HACK_FETCH_STATS_EN
      if (c == 0) chk("s1_stat_f0", stat_fetches, 32'd0);
`endif
      if (c == 0) chk("w4_req_redirect", 32'(rom_req4), 32'd0);
      if (c == 3) begin
        chk("w4_valid15", 32'(instr_valid4), 32'd1);
        chk("w4_pc15", 32'(instr_pc4), 32'd15);
        chk("w4_instr15", 32'(instr4), 32'(word(15)));
      end
      if (c == 4) begin
        chk("w4_req_wrap", 32'(rom_req4), 32'd1);
        chk("w4_addr_wrap", 32'(rom_addr4), 32'd0);
      end
      if (c == 6) begin
        chk("w4_pc0", 32'(instr_pc4), 32'd0);
        chk("w4_instr0", 32'(instr4), 32'(word(0)));
      end
      tick();
    end

    // Cycle 12: request addr 4, then back-pressure for 5 cycles while FULL.
    instr_ready = 1'b0;
    #1;
    chk("bp_req", 32'(rom_req), 32'd1);
    chk("bp_addr", 32'(rom_addr), 32'd4);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(instr_valid), 32'd1);
      chk("bp_hold_pc", 32'(instr_pc), 32'd4);
      chk("bp_hold_instr", 32'(instr), 32'(word(4)));
      chk("bp_hold_noreq", 32'(rom_req), 32'd0);
      tick();
    end
    instr_ready = 1'b1;
    #1;
    chk("bp_still_valid", 32'(instr_valid), 32'd1);
    tick();
    chk("bp_after_req", 32'(rom_req), 32'd1);
    chk("bp_after_addr", 32'(rom_addr), 32'd5);
    chk("bp_after_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("bp_single_req", 32'(rom_req), 32'd0);
    wait_valid("bp_wait5", 10);
    chk("bp_pc5", 32'(instr_pc), 32'd5);
    tick();

    // Redirect to 0x0100 during WAIT with k=3: stale word must be dropped.
    lat = 3;
    #1;
    chk("rw_req", 32'(rom_req), 32'd1);
    chk("rw_addr", 32'(rom_addr), 32'd6);
    tick();
    set_jump(1'b1, 1'b1, 15'h0100);
    #1;
    chk("rw_wait_noreq", 32'(rom_req), 32'd0);
    tick();
    set_jump(1'b0, 1'b0, 15'h0000);
    #1;
    chk("rw_drop_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("rw_stale_arrives", 32'(rom_valid), 32'd1);
    chk("rw_stale_noreq", 32'(rom_req), 32'd0);
    tick();
    chk("rw_stale_novalid", 32'(instr_valid), 32'd0);
    chk("rw_new_req", 32'(rom_req), 32'd1);
    chk("rw_new_addr", 32'(rom_addr), 32'h100);
    wait_valid("rw_wait", 10);
    chk("rw_pc", 32'(instr_pc), 32'h100);
    chk("rw_instr", 32'(instr), 32'(word(32'h100)));

    // Redirect while instr_valid & instr_ready: word squashed, fetch 0x0300.
    lat = 1;
    set_jump(1'b1, 1'b1, 15'h0300);
    tick();
    set_jump(1'b0, 1'b0, 15'h0000);
    #1;
    chk("rf_valid", 32'(instr_valid), 32'd0);
    chk("rf_req", 32'(rom_req), 32'd1);
    chk("rf_addr", 32'(rom_addr), 32'h300);
    tick();

    // Redirect in the same cycle as rom_valid: data dropped, fetch 0x0200.
    chk("rv_rom_valid", 32'(rom_valid), 32'd1);
    set_jump(1'b1, 1'b1, 15'h0200);
    tick();
    set_jump(1'b0, 1'b0, 15'h0000);
    #1;
    chk("rv_valid", 32'(instr_valid), 32'd0);
    chk("rv_req", 32'(rom_req), 32'd1);
    chk("rv_addr", 32'(rom_addr), 32'h200);

    // Redirect in FETCH to the top address, then wrap to 0.
    set_jump(1'b1, 1'b1, 15'h7FFF);
    #1;
    chk("rt_fetch_noreq", 32'(rom_req), 32'd0);
    tick();
    set_jump(1'b0, 1'b0, 15'h0000);
    #1;
    chk("rt_req", 32'(rom_req), 32'd1);
    chk("rt_addr", 32'(rom_addr), 32'h7FFF);
    tick();
    tick();
    chk("rt_valid", 32'(instr_valid), 32'd1);
    chk("rt_pc", 32'(instr_pc), 32'h7FFF);
    chk("rt_instr", 32'(instr), 32'(word(32'h7FFF)));
    tick();
    chk("rt_wrap_addr", 32'(rom_addr), 32'd0);

    // jumpctrl with ex_valid=0 is ignored throughout a full fetch.
    set_jump(1'b0, 1'b1, 15'h0555);
    #1;
    chk("ig_req", 32'(rom_req), 32'd1);
    chk("ig_addr", 32'(rom_addr), 32'd0);
    tick();
    tick();
    chk("ig_valid", 32'(instr_valid), 32'd1);
    chk("ig_pc", 32'(instr_pc), 32'd0);
    chk("ig_instr", 32'(instr), 32'(word(0)));
    tick();
    chk("ig_next_addr", 32'(rom_addr), 32'd1);
    set_jump(1'b0, 1'b0, 15'h0000);

    // Reset asserted in WAIT with a k=3 read outstanding.
    lat = 3;
    tick();
    reset = 1'b1;
    #1;
    chk("rs_req_in_reset", 32'(rom_req), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rs_req", 32'(rom_req), 32'd1);
    chk("rs_addr", 32'(rom_addr), 32'd0);
    chk("rs_valid", 32'(instr_valid), 32'd0);
`ifdef HACK_FETCH_STATS_EN
    chk("rs_stat_f", stat_fetches, 32'd0);
    chk("rs_stat_r", stat_redirects, 32'd0);
`endif
    wait_valid("rs_wait", 10);
    chk("rs_pc", 32'(instr_pc), 32'd0);
    chk("rs_instr", 32'(instr), 32'(word(0)));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
